pipeline_trace_monitor: RTL and testbench

PIPELINE_TRACE_MONITOR -- requirements
Module: pipeline_trace_monitor

---
 rtl/pipeline_trace_monitor.sv | 126 ++++++++++++
 tb/tb_pipeline_trace_monitor.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_trace_monitor.sv
// Captures {PC, WriteBack} samples into a circular trace buffer during a fixed-length
// window opened by Start; the buffer is read back oldest-first through RdAddr.
module pipeline_trace_monitor #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int RUN_CYCLES = 40
) (
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic                              Start,
    input  logic                              Mode,
    input  logic                              Valid,
    input  logic [DATA_WIDTH-1:0]             PC,
    input  logic [DATA_WIDTH-1:0]             WriteBack,
    input  logic [$clog2(DEPTH)-1:0]          RdAddr,
    output logic [DATA_WIDTH-1:0]             RdPC,
    output logic [DATA_WIDTH-1:0]             RdWB,
    output logic [$clog2(DEPTH):0]            Count,
    output logic                              Wrapped,
    output logic                              Busy,
    output logic                              Done,
    output logic [$clog2(RUN_CYCLES+1)-1:0]   CycleCnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(RUN_CYCLES + 1);
    localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] RUN_LAST = CW'(RUN_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [AW:0]           cnt_q, cnt_d;
    logic                  wrapped_q, wrapped_d;
    logic [CW-1:0]         cyc_q, cyc_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         old_ptr_q, old_ptr_d;
    logic [DATA_WIDTH-1:0] last_wb_q, last_wb_d;
    logic                  cap;
    logic [AW-1:0]         rd_idx;

    logic [DATA_WIDTH-1:0] pc_mem [DEPTH];
    logic [DATA_WIDTH-1:0] wb_mem [DEPTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wrapped_d = wrapped_q;
        cyc_d     = cyc_q;
        wr_ptr_d  = wr_ptr_q;
        old_ptr_d = old_ptr_q;
        last_wb_d = last_wb_q;
        cap       = 1'b0;
        case (state_q)
            S_RUN: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == RUN_LAST) state_d = S_DONE;
                // An empty buffer always accepts, so change-only mode has a reference value.
                cap = Valid && (!Mode || cnt_q == '0 || WriteBack != last_wb_q);
                if (cap) begin
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    last_wb_d = WriteBack;
                    if (cnt_q == FULL) begin
                        old_ptr_d = old_ptr_q + 1'b1;
                        wrapped_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                if (Start) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    wrapped_d = 1'b0;
                    cyc_d     = '0;
                    wr_ptr_d  = '0;
                    old_ptr_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wrapped_q <= 1'b0;
            cyc_q     <= '0;
            wr_ptr_q  <= '0;
            old_ptr_q <= '0;
            last_wb_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wrapped_q <= wrapped_d;
            cyc_q     <= cyc_d;
            wr_ptr_q  <= wr_ptr_d;
            old_ptr_q <= old_ptr_d;
            last_wb_q <= last_wb_d;
        end
    end

    // Storage is not reset; Count gates every read so stale entries never show.
    always_ff @(posedge Clk) begin
        if (Reset && cap) begin
            pc_mem[wr_ptr_q] <= PC;
            wb_mem[wr_ptr_q] <= WriteBack;
        end
    end

    always_comb begin
        rd_idx = old_ptr_q + RdAddr;
        RdPC   = '0;
        RdWB   = '0;
        if ({1'b0, RdAddr} < cnt_q) begin
            RdPC = pc_mem[rd_idx];
            RdWB = wb_mem[rd_idx];
        end
    end

    assign Count    = cnt_q;
    assign Wrapped  = wrapped_q;
    assign CycleCnt = cyc_q;
    assign Busy     = (state_q == S_RUN);
    assign Done     = (state_q == S_DONE);
endmodule

// File: tb/tb_pipeline_trace_monitor.sv
// Random and directed capture windows on a default and a small (DEPTH=4, RUN_CYCLES=6)
// instance; a queue-fed monitor checks window results on Done and state snapshots.
module tb_pipeline_trace_monitor;
    logic clk = 1'b0;
    always #50 clk = ~clk;

    logic [1:0]       rst_n, start, mode, valid;
    logic [1:0][31:0] pc, wb;
    logic [3:0]       ra0;
    logic [1:0]       ra1;
    logic [31:0]      rdpc0, rdwb0, rdpc1, rdwb1;
    logic [4:0]       cnt0;
    logic [2:0]       cnt1;
    logic [5:0]       cyc0;
    logic [2:0]       cyc1;
    logic             wr0, wr1, busy0, busy1, done0, done1;

    pipeline_trace_monitor dut0 (
        .Clk(clk), .Reset(rst_n[0]), .Start(start[0]), .Mode(mode[0]), .Valid(valid[0]),
        .PC(pc[0]), .WriteBack(wb[0]), .RdAddr(ra0), .RdPC(rdpc0), .RdWB(rdwb0),
        .Count(cnt0), .Wrapped(wr0), .Busy(busy0), .Done(done0), .CycleCnt(cyc0)
    );

    pipeline_trace_monitor #(.DATA_WIDTH(32), .DEPTH(4), .RUN_CYCLES(6)) dut1 (
        .Clk(clk), .Reset(rst_n[1]), .Start(start[1]), .Mode(mode[1]), .Valid(valid[1]),
        .PC(pc[1]), .WriteBack(wb[1]), .RdAddr(ra1), .RdPC(rdpc1), .RdWB(rdwb1),
        .Count(cnt1), .Wrapped(wr1), .Busy(busy1), .Done(done1), .CycleCnt(cyc1)
    );

    typedef struct {
        int          d;
        logic [31:0] cnt;
        logic [31:0] wrapped;
        logic [31:0] blen;
        logic [31:0] epc [16];
        logic [31:0] ewb [16];
    } win_t;

    typedef struct {
        int          d;
        logic [31:0] busy, done, cnt, wrapped, cyc, rdpc, rdwb;
    } st_t;

    win_t win_q[$];
    st_t  st_q[$];
    int   total = 0;
    int   bad = 0;

    function automatic int runc(int d); return (d != 0) ? 6 : 40; endfunction
    function automatic int dep(int d);  return (d != 0) ? 4 : 16; endfunction

    function automatic logic [31:0] g_busy(int d); return 32'((d != 0) ? busy1 : busy0); endfunction
    function automatic logic [31:0] g_done(int d); return 32'((d != 0) ? done1 : done0); endfunction
    function automatic logic [31:0] g_wr(int d);   return 32'((d != 0) ? wr1 : wr0); endfunction
    function automatic logic [31:0] g_cnt(int d);  return (d != 0) ? 32'(cnt1) : 32'(cnt0); endfunction
    function automatic logic [31:0] g_cyc(int d);  return (d != 0) ? 32'(cyc1) : 32'(cyc0); endfunction
    function automatic logic [31:0] g_rdpc(int d); return (d != 0) ? rdpc1 : rdpc0; endfunction
    function automatic logic [31:0] g_rdwb(int d); return (d != 0) ? rdwb1 : rdwb0; endfunction

    task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h want %0h (t=%0t)", nm, d, act, exp, $time);
        end
    endtask

    // Monitor: state snapshots queued at a posedge are checked at the next negedge;
    // a window result is checked when Done rises.
    int         blen [2] = '{0, 0};
    logic [1:0] dprev = 2'b00;
    st_t        s;
    win_t       w;

    task automatic check_win(int d);
        if (win_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done dut%0d", d);
            return;
        end
        w = win_q.pop_front();
        chk("win_owner", d, 32'(d), 32'(w.d));
        chk("count", d, g_cnt(d), w.cnt);
        chk("wrapped", d, g_wr(d), w.wrapped);
        chk("cyclecnt_hold", d, g_cyc(d), 32'(runc(d)));
        chk("busy_len", d, 32'(blen[d]), w.blen);
        for (int i = 0; i < dep(d); i++) begin
            if (d == 0) ra0 = 4'(i); else ra1 = 2'(i);
            #2;
            chk("rd_pc", d, g_rdpc(d), (i < int'(w.cnt)) ? w.epc[i] : 32'h0);
            chk("rd_wb", d, g_rdwb(d), (i < int'(w.cnt)) ? w.ewb[i] : 32'h0);
        end
        ra0 = 4'd0;
        ra1 = 2'd0;
    endtask

    initial begin
        ra0 = 4'd0;
        ra1 = 2'd0;
    end

    always @(negedge clk) begin
        while (st_q.size() > 0) begin
            s = st_q.pop_front();
            chk("st_busy", s.d, g_busy(s.d), s.busy);
            chk("st_done", s.d, g_done(s.d), s.done);
            chk("st_count", s.d, g_cnt(s.d), s.cnt);
            chk("st_wrapped", s.d, g_wr(s.d), s.wrapped);
            chk("st_cyclecnt", s.d, g_cyc(s.d), s.cyc);
            chk("st_rdpc", s.d, g_rdpc(s.d), s.rdpc);
            chk("st_rdwb", s.d, g_rdwb(s.d), s.rdwb);
        end
        for (int d = 0; d < 2; d++) begin
            if (g_busy(d) != 0) begin
                blen[d]++;
            end else begin
                if (g_done(d) != 0 && !dprev[d]) check_win(d);
                blen[d] = 0;
            end
            dprev[d] = (g_done(d) != 0);
        end
    end

    task automatic push_st(int d, bit b, bit dn, int c, bit wrp, int cy);
        st_t x;
        x.d = d; x.busy = 32'(b); x.done = 32'(dn); x.cnt = 32'(c);
        x.wrapped = 32'(wrp); x.cyc = 32'(cy); x.rdpc = 32'h0; x.rdwb = 32'h0;
        st_q.push_back(x);
    endtask

    // kind: 0 random, 1 PC ramp, 2 change-only 5,5,5,7,7,9, 3 three valid samples,
    //       4 random with Start re-pulsed at cycle 10, 5 random aborted by reset at cycle 20
    task automatic run_window(int d, int kind);
        logic [31:0] cpc[$];
        logic [31:0] cwb[$];
        logic [31:0] lastwb = 32'h0;
        logic [31:0] seq[6] = '{32'd5, 32'd5, 32'd5, 32'd7, 32'd7, 32'd9};
        win_t x;
        int n;
        int keep;
        @(negedge clk);
        start[d] = 1'b1;
        valid[d] = 1'b0;
        @(posedge clk);
        push_st(d, 1'b1, 1'b0, 0, 1'b0, 0);
        for (int k = 0; k < runc(d); k++) begin
            @(negedge clk);
            start[d] = (kind == 4 && k == 10);
            case (kind)
                1: begin mode[d] = 1'b0; valid[d] = 1'b1; pc[d] = 32'(4 * k); wb[d] = 32'(4 * k + 1); end
                2: begin mode[d] = 1'b1; valid[d] = (k < 6); pc[d] = $urandom; wb[d] = (k < 6) ? seq[k] : 32'd0; end
                3: begin mode[d] = 1'b0; valid[d] = (k == 2 || k == 17 || k == 31); pc[d] = $urandom; wb[d] = $urandom; end
                default: begin
                    if ($urandom_range(0, 5) == 0) mode[d] = ~mode[d];
                    valid[d] = ($urandom_range(0, 3) != 0);
                    pc[d] = $urandom;
                    wb[d] = 32'($urandom_range(0, 3));
                end
            endcase
            if (kind == 5 && k == 20) begin
                valid[d] = 1'b1;
                rst_n[d] = 1'b0;
                @(posedge clk);
                push_st(d, 1'b0, 1'b0, 0, 1'b0, 0);
                @(negedge clk);
                rst_n[d] = 1'b1;
                valid[d] = 1'b0;
                return;
            end
            if (valid[d] && (!mode[d] || cpc.size() == 0 || wb[d] != lastwb)) begin
                cpc.push_back(pc[d]);
                cwb.push_back(wb[d]);
                lastwb = wb[d];
            end
        end
        n = cpc.size();
        keep = (n < dep(d)) ? n : dep(d);
        x.d = d;
        x.cnt = 32'(keep);
        x.wrapped = 32'(n > dep(d));
        x.blen = 32'(runc(d));
        for (int i = 0; i < 16; i++) begin
            x.epc[i] = (i < keep) ? cpc[n - keep + i] : 32'h0;
            x.ewb[i] = (i < keep) ? cwb[n - keep + i] : 32'h0;
        end
        win_q.push_back(x);
        @(negedge clk);
        valid[d] = 1'b0;
        start[d] = 1'b0;
        for (int t = 0; t < 5 && win_q.size() > 0; t++) @(negedge clk);
        if (win_q.size() > 0) begin
            $display("FAIL done_timeout dut%0d: Done never rose", d);
            $fatal(1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 2'b00;
        start = 2'b11;
        mode = 2'b00;
        valid = 2'b11;
        pc = '0;
        wb = '0;
        @(posedge clk);
        @(posedge clk);
        push_st(0, 1'b0, 1'b0, 0, 1'b0, 0);
        push_st(1, 1'b0, 1'b0, 0, 1'b0, 0);
        @(negedge clk);
        start = 2'b00;
        valid = 2'b00;
        @(negedge clk);
        rst_n = 2'b11;
        @(posedge clk);
        push_st(0, 1'b0, 1'b0, 0, 1'b0, 0);
        push_st(1, 1'b0, 1'b0, 0, 1'b0, 0);

        run_window(0, 1);
        run_window(0, 2);
        run_window(0, 3);
        run_window(0, 4);
        run_window(0, 5);
        for (int i = 0; i < 4; i++) run_window(0, 0);
        run_window(1, 1);
        for (int i = 0; i < 6; i++) run_window(1, 0);
        run_window(1, 2);
        run_window(1, 5);
        run_window(1, 1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
